// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack handshake,
// presents each word to the decoder for one cycle, and applies redirects or halts.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [15:0] branch_im,
  input  logic        jump,
  input  logic [25:0] jump_adr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr, instr_nxt;
  logic [31:0] ret_cnt, ret_cnt_nxt;
  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4         = pc + 32'd4;
  assign br_off      = {{14{branch_im[15]}}, branch_im, 2'b00};
  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign pc_plus4    = pc4;
  assign instr_out   = instr;
  assign retired     = ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= '0;
      ret_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr   <= instr_nxt;
      ret_cnt <= ret_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr;
    ret_cnt_nxt = ret_cnt;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        ret_cnt_nxt = ret_cnt + 32'd1;
        // A halt retires but leaves the PC pointing at itself.
        if (instr == HALT_WORD) begin
          state_nxt = HALT;
        end else begin
          if (jr)                pc_nxt = {jr_target[31:2], 2'b00};
          else if (jump)         pc_nxt = {pc4[31:28], jump_adr, 2'b00};
          else if (branch_taken) pc_nxt = pc4 + br_off;
          else                   pc_nxt = pc4;
          state_nxt = en ? FETCH : IDLE;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + randomized bench for instr_fetch, checked against an arithmetic PC/retire model.
module tb_instr_fetch;

  localparam logic [31:0] HALT_W = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [15:0] branch_im;
  logic        jump;
  logic [25:0] jump_adr;
  logic        jr;
  logic [31:0] jr_target;
  logic        halted;
  logic [31:0] retired;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_halt;

  instr_fetch #(.RESET_PC(32'h0000_0000), .HALT_WORD(HALT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_im(branch_im), .jump(jump), .jump_adr(jump_adr),
    .jr(jr), .jr_target(jr_target), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_W) w = w + 32'd1;
    return w;
  endfunction

  task automatic rand_redirects();
    branch_taken = 1'($urandom_range(0, 1));
    branch_im    = 16'($urandom);
    jump         = 1'($urandom_range(0, 1));
    jump_adr     = 26'($urandom);
    jr           = 1'($urandom_range(0, 1));
    jr_target    = $urandom;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0; branch_im = '0; jump = 1'b0; jump_adr = '0; jr = 1'b0; jr_target = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_instr"}, instr_out, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
    chk({tag, "_retired"}, retired, 32'h0);
  endtask

  // Starts with the DUT in FETCH; ends in FETCH again unless the word halts.
  task automatic do_instr(input logic [31:0] w, input int unsigned dly,
                          input logic a_br, input logic [15:0] a_im,
                          input logic a_j, input logic [25:0] a_ja,
                          input logic a_jr, input logic [31:0] a_jt, input logic a_en);
    logic [31:0] pc0;
    pc0 = m_pc;
    chk("fetch_req", {31'b0, imem_req}, 32'h1);
    chk("fetch_addr", imem_addr, pc0);
    for (int unsigned i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      en = 1'($urandom_range(0, 1));
      rand_redirects();
      step();
      chk("wait_req", {31'b0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, pc0);
      chk("wait_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    en = 1'($urandom_range(0, 1));
    rand_redirects();
    step();
    imem_ack = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    chk("exec_valid", {31'b0, instr_valid}, 32'h1);
    chk("exec_instr", instr_out, w);
    chk("exec_pc", pc_out, pc0);
    chk("exec_pc4", pc_plus4, pc0 + 32'd4);
    chk("exec_req", {31'b0, imem_req}, 32'h0);
    branch_taken = a_br; branch_im = a_im; jump = a_j; jump_adr = a_ja;
    jr = a_jr; jr_target = a_jt; en = a_en;
    step();
    clear_redirects();
    imem_ack = 1'b0;
    m_ret = m_ret + 32'd1;
    if (w == HALT_W)   m_halt = 1'b1;
    else if (a_jr)     m_pc = a_jt & 32'hFFFF_FFFC;
    else if (a_j)      m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(a_ja) * 32'd4);
    else if (a_br)     m_pc = m_pc + 32'd4 + 32'(int'($signed(a_im)) * 4);
    else               m_pc = m_pc + 32'd4;
    chk("post_pc", pc_out, m_pc);
    chk("post_retired", retired, m_ret);
    chk("post_halted", {31'b0, halted}, {31'b0, m_halt});
    chk("post_valid", {31'b0, instr_valid}, 32'h0);
    if (!m_halt && !a_en) begin
      imem_ack = 1'b1;
      step();
      chk("idle_req", {31'b0, imem_req}, 32'h0);
      chk("idle_pc", pc_out, m_pc);
      imem_ack = 1'b0;
      en = 1'b1;
      step();
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_pc = 32'h0; m_ret = '0; m_halt = 1'b0;
    check_reset_values("async_reset");
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    clear_redirects();
    m_pc = 32'h0; m_ret = '0; m_halt = 1'b0;
    #1;
    check_reset_values("reset");

    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_no_en", {31'b0, imem_req}, 32'h0);
    en = 1'b1;
    step();

    // Back-to-back sequential fetches with zero-wait memory.
    for (int k = 0; k < 4; k++)
      do_instr(rand_word(), 0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("seq_retired", retired, 32'd4);
    chk("seq_pc", pc_out, 32'h10);

    do_instr(rand_word(), 3, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);

    do_instr(rand_word(), 0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0100, 1'b1);
    do_instr(rand_word(), 1, 1'b1, 16'hFFFE, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("branch_back", pc_out, 32'h0000_00FC);

    do_instr(rand_word(), 0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h1000_0000, 1'b1);
    do_instr(rand_word(), 0, 1'b0, '0, 1'b1, 26'h0000040, 1'b0, '0, 1'b1);
    chk("jump_target", pc_out, 32'h1000_0100);

    do_instr(rand_word(), 0, 1'b1, 16'h0010, 1'b1, 26'h1234, 1'b1, 32'h0000_0203, 1'b1);
    chk("jr_priority", pc_out, 32'h0000_0200);

    do_instr(rand_word(), 0, 1'b0, '0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("pre_wrap_pc", pc_out, 32'hFFFF_FFFC);
    do_instr(rand_word(), 2, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("pc_wrap", pc_out, 32'h0);

    for (int k = 0; k < 40; k++)
      do_instr(rand_word(), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0), 16'($urandom),
               ($urandom_range(0, 3) == 0), 26'($urandom),
               ($urandom_range(0, 3) == 0), $urandom,
               ($urandom_range(0, 3) != 0));

    // Reset while a request is pending, then a stale ack after release.
    imem_ack = 1'b0;
    step();
    chk("pending_req", {31'b0, imem_req}, 32'h1);
    do_reset();
    imem_ack = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("stale_ack_valid", {31'b0, instr_valid}, 32'h0);
    chk("stale_ack_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("stale_ack_valid2", {31'b0, instr_valid}, 32'h0);
    imem_ack = 1'b0;

    // Halt word at 0x8.
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    step();
    do_instr(rand_word(), 0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    do_instr(rand_word(), 1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    do_instr(HALT_W, 0, 1'b1, 16'h0040, 1'b1, 26'h3, 1'b1, 32'h400, 1'b1);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_pc", pc_out, 32'h8);
    chk("halt_retired", retired, 32'd3);
    en = 1'b1;
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halt_req", {31'b0, imem_req}, 32'h0);
      chk("halt_valid", {31'b0, instr_valid}, 32'h0);
      chk("halt_hold", {31'b0, halted}, 32'h1);
    end
    chk("halt_pc_hold", pc_out, 32'h8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
